// File: rtl/uart_tx_stream.sv
// uart_tx_stream: parametrised UART transmitter fed by a valid/ready stream.
// Words are queued in a small FIFO and sent as back-to-back frames:
// start bit, DATABITS data bits LSB first, optional parity, STOPBITS stop bits.
module uart_tx_stream #(
    parameter int unsigned CLKFREQ    = 100_000_000,
    parameter int unsigned BAUDRATE   = 115_200,
    parameter int unsigned DATABITS   = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOPBITS   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_i,
    input  logic [DATABITS-1:0]              din_i,
    input  logic                             din_valid_i,
    output logic                             din_ready_o,
    output logic                             tx_o,
    output logic                             tx_busy_o,
    output logic                             tx_done_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o
);

    localparam int unsigned BITCYC = CLKFREQ / BAUDRATE;
    localparam int unsigned PW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);

    if (DATABITS < 5 || DATABITS > 9) begin : g_bad_databits
        $error("uart_tx_stream: DATABITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_stream: PARITY must be 0, 1 or 2");
    end
    if (STOPBITS < 1 || STOPBITS > 2) begin : g_bad_stopbits
        $error("uart_tx_stream: STOPBITS must be 1 or 2");
    end
    if (BITCYC < 2) begin : g_bad_bitcyc
        $error("uart_tx_stream: CLKFREQ/BAUDRATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // FIFO storage and bookkeeping
    logic [DATABITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;

    // Transmit engine
    state_e              r_state;
    logic [31:0]         r_timer;
    logic [3:0]          r_bitcnt;
    logic                r_stopcnt;
    logic [DATABITS-1:0] r_shift;
    logic                r_par;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    logic                w_push;
    logic                w_pop;
    logic                w_bit_end;
    logic                w_stop_last;
    logic [DATABITS-1:0] w_head;
    logic                w_head_par;

    assign din_ready_o = !rst_i && (r_count < CW'(FIFO_DEPTH));
    assign w_push      = din_valid_i && din_ready_o;
    assign w_bit_end   = (r_timer == BITCYC - 1);
    assign w_stop_last = (r_stopcnt == 1'(STOPBITS - 1));
    assign w_head      = r_mem[r_rptr];
    // Odd mode sets the bit when the data holds an even number of ones.
    assign w_head_par  = (PARITY == 1) ? ~^w_head : ^w_head;

    // Pop from idle, or at the final stop cycle so the next start follows with no gap.
    assign w_pop = (r_count != '0) &&
                   ((r_state == StIdle) ||
                    (r_state == StStop && w_bit_end && w_stop_last));

    // FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // FIFO data write; contents need no reset since the count guards reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din_i;
        end
    end

    // Frame sequencer with registered line, busy and done outputs
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_timer   <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != StIdle) begin
                r_timer <= w_bit_end ? '0 : r_timer + 32'd1;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= w_head_par;
                        r_state <= StStart;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_state  <= StData;
                        r_tx     <= r_shift[0];
                        r_bitcnt <= '0;
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        if (r_bitcnt == 4'(DATABITS - 1)) begin
                            if (PARITY != 0) begin
                                r_state <= StParity;
                                r_tx    <= r_par;
                            end else begin
                                r_state   <= StStop;
                                r_tx      <= 1'b1;
                                r_stopcnt <= 1'b0;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                            r_shift  <= r_shift >> 1;
                            r_tx     <= r_shift[1];
                        end
                    end
                end
                StParity: begin
                    if (w_bit_end) begin
                        r_state   <= StStop;
                        r_tx      <= 1'b1;
                        r_stopcnt <= 1'b0;
                    end
                end
                StStop: begin
                    // Raise done one cycle early so it lands on the final stop cycle.
                    if (w_stop_last && r_timer == BITCYC - 2) begin
                        r_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        if (!w_stop_last) begin
                            r_stopcnt <= 1'b1;
                        end else if (w_pop) begin
                            r_shift <= w_head;
                            r_par   <= w_head_par;
                            r_state <= StStart;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o         = r_tx;
    assign tx_busy_o    = r_busy;
    assign tx_done_o    = r_done;
    assign fifo_count_o = r_count;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Testbench for uart_tx_stream: three parameter sets, each checked every cycle
// against a frame-timeline model plus hand-computed literal frames.
module tb_uart_tx_stream;

    localparam int unsigned C_CLK   [3] = '{16, 10, 5};
    localparam int unsigned C_BAUD  [3] = '{1, 3, 2};
    localparam int unsigned C_DB    [3] = '{8, 7, 9};
    localparam int unsigned C_PAR   [3] = '{2, 1, 0};
    localparam int unsigned C_SB    [3] = '{1, 2, 1};
    localparam int unsigned C_DEPTH [3] = '{4, 2, 8};
    // Pinned frames: word, line bits (bit k = k-th bit on the wire), frame length.
    localparam logic [8:0]  C_PINW  [3] = '{9'h0A5, 9'h055, 9'h1FF};
    localparam logic [11:0] C_PINB  [3] = '{12'b0101_0100_1010, 12'b0111_1010_1010,
                                            12'b0111_1111_1110};
    localparam int          C_PINL  [3] = '{176, 33, 22};
    localparam int          C_BURST [3] = '{5, 3, 7};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int cfg, input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL cfg%0d %s: got %0h want %0h at %0t", cfg, nm, got, want, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned BITCYC = C_CLK[g] / C_BAUD[g];
        localparam int unsigned DB     = C_DB[g];
        localparam int unsigned PAR    = C_PAR[g];
        localparam int unsigned SB     = C_SB[g];
        localparam int unsigned DEPTH  = C_DEPTH[g];
        localparam int          NBITS  = 1 + int'(DB) + ((PAR != 0) ? 1 : 0) + int'(SB);
        localparam int          BC     = int'(BITCYC);
        localparam int          FL     = NBITS * BC;
        localparam int          CW     = $clog2(DEPTH + 1);

        logic          rst   = 1'b1;
        logic          valid = 1'b0;
        logic [DB-1:0] din   = '0;
        logic          ready;
        logic          tx;
        logic          busy;
        logic          done;
        logic [CW-1:0] cnt;
        bit            fin   = 1'b0;

        uart_tx_stream #(
            .CLKFREQ   (C_CLK[g]),
            .BAUDRATE  (C_BAUD[g]),
            .DATABITS  (DB),
            .PARITY    (PAR),
            .STOPBITS  (SB),
            .FIFO_DEPTH(DEPTH)
        ) u_dut (
            .clk         (clk),
            .rst_i       (rst),
            .din_i       (din),
            .din_valid_i (valid),
            .din_ready_o (ready),
            .tx_o        (tx),
            .tx_busy_o   (busy),
            .tx_done_o   (done),
            .fifo_count_o(cnt)
        );

        // Line bit k of a frame carrying word w.
        function automatic logic frame_bit(input logic [8:0] w, input int k);
            int ones;
            if (k == 0) return 1'b0;
            if (k <= int'(DB)) return w[k-1];
            if (PAR != 0 && k == int'(DB) + 1) begin
                ones = 0;
                for (int i = 0; i < int'(DB); i++) ones += int'(w[i]);
                return (PAR == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            end
            return 1'b1;
        endfunction

        // Model: queue of accepted words and position within the current frame.
        logic [8:0] mq [$];
        bit         m_act  = 1'b0;
        bit         m_live = 1'b0;
        int         m_t    = 0;
        int         m_acc  = 0;
        logic [8:0] m_word = '0;

        initial forever begin
            bit acc;
            @(posedge clk);
            acc = valid && !rst && (mq.size() < int'(DEPTH));
            if (rst) begin
                mq.delete();
                m_act  = 1'b0;
                m_t    = 0;
                m_live = 1'b1;
            end else begin
                if (!m_act || m_t == FL - 1) begin
                    if (mq.size() > 0) begin
                        m_word = mq.pop_front();
                        m_act  = 1'b1;
                        m_t    = 0;
                    end else begin
                        m_act = 1'b0;
                    end
                end else begin
                    m_t++;
                end
                if (acc) begin
                    mq.push_back(9'(din));
                    m_acc++;
                end
            end
        end

        // Per-cycle comparison of all outputs against the model.
        initial forever begin
            logic [CW+3:0] exp_v;
            logic [CW+3:0] act_v;
            @(negedge clk);
            if (m_live) begin
                exp_v = {(m_act ? frame_bit(m_word, m_t / BC) : 1'b1), m_act,
                         (m_act && m_t == FL - 1), CW'(mq.size()),
                         (!rst && mq.size() < int'(DEPTH))};
                act_v = {tx, busy, done, cnt, ready};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL cfg%0d cycle {tx,busy,done,cnt,rdy}: got %b want %b at %0t",
                             g, act_v, exp_v, $time);
                end
            end
        end

        initial begin
            logic [8:0]  pw;
            logic [11:0] seen;
            int          c;
            int          len;
            int          nd;
            int          acc0;
            int          first_acc;

            pw   = C_PINW[g];
            seen = '0;
            for (int k = 0; k < NBITS; k++) seen[k] = frame_bit(pw, k);
            chk(g, "model_pin_bits", 32'(seen), 32'(C_PINB[g]));
            chk(g, "model_pin_len", 32'(FL), 32'(C_PINL[g]));

            // Reset state
            tick();
            tick();
            chk(g, "rst_ready", 32'(ready), 32'd0);
            chk(g, "rst_tx", 32'(tx), 32'd1);
            chk(g, "rst_busy", 32'(busy), 32'd0);
            chk(g, "rst_cnt", 32'(cnt), 32'd0);
            rst = 1'b0;
            #1;
            chk(g, "ready_after_rst", 32'(ready), 32'd1);

            // Pinned single frame
            din   = pw[DB-1:0];
            valid = 1'b1;
            tick();
            valid = 1'b0;
            din   = '1;
            c = 0;
            while (tx !== 1'b0 && c < 8) begin
                tick();
                c++;
            end
            chk(g, "pin_start", 32'(tx), 32'd0);
            seen = '0;
            len  = 0;
            nd   = 0;
            for (int i = 0; i < FL + 8; i++) begin
                if ((i % BC) == BC / 2 && i < FL) seen[i / BC] = tx;
                if (done === 1'b1) begin
                    nd++;
                    if (len == 0) len = i + 1;
                end
                tick();
            end
            chk(g, "pin_bits", 32'(seen), 32'(C_PINB[g]));
            chk(g, "pin_len", 32'(len), 32'(C_PINL[g]));
            chk(g, "pin_done_count", 32'(nd), 32'd1);

            // Burst of words 1..7 with valid held high
            acc0      = m_acc;
            first_acc = -1;
            nd        = 0;
            valid     = 1'b1;
            din       = DB'(1);
            for (c = 0; c < 10 * FL; c++) begin
                tick();
                if (done === 1'b1) begin
                    nd++;
                    if (first_acc < 0) first_acc = m_acc - acc0;
                end
                if (m_acc - acc0 >= 7) valid = 1'b0;
                din = DB'(m_acc - acc0 + 1);
                if (!valid && !m_act && mq.size() == 0) break;
            end
            chk(g, "burst_acc_before_done", 32'(first_acc), 32'(C_BURST[g]));
            chk(g, "burst_done_count", 32'(nd), 32'd7);

            // Reset during data bit 3 with words queued
            valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                din = DB'($urandom);
                tick();
            end
            valid = 1'b0;
            c = 0;
            while (!(m_act && (m_t / BC) == 4) && c < 2 * FL) begin
                tick();
                c++;
            end
            chk(g, "abort_reached_bit3", 32'(busy), 32'd1);
            rst = 1'b1;
            tick();
            chk(g, "abort_tx", 32'(tx), 32'd1);
            chk(g, "abort_cnt", 32'(cnt), 32'd0);
            chk(g, "abort_done", 32'(done), 32'd0);
            rst   = 1'b0;
            din   = DB'(9'h03C);
            valid = 1'b1;
            tick();
            valid = 1'b0;
            for (c = 0; c < 3 * FL && (m_act || mq.size() != 0); c++) tick();
            chk(g, "after_abort_idle", 32'(busy), 32'd0);

            // Randomised traffic with rare resets
            for (int i = 0; i < 1500; i++) begin
                valid = ($urandom_range(0, 3) != 0);
                din   = DB'($urandom);
                rst   = ($urandom_range(0, 499) == 0);
                tick();
            end
            rst   = 1'b0;
            valid = 1'b0;
            for (c = 0; c < (int'(DEPTH) + 2) * FL && (m_act || mq.size() != 0); c++) tick();
            tick();
            chk(g, "drain_idle", 32'(busy), 32'd0);
            fin = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 90000; c++) begin
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
            @(posedge clk);
        end
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
            total++;
            bad++;
            $display("FAIL watchdog: stimulus did not complete within cycle budget");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
